// File: rtl/ps_noc_gw.sv
// rtl/ps_noc_gw.sv - NoC byte-stream gateway to the permutation engine
// Optional trailing XOR checksum byte on responses when PS_NOC_GW_CSUM_EN is defined.
module ps_noc_gw #(
  parameter int              DW     = 8,
  parameter int              LW     = 64,
  parameter int              NLANES = 25,
  parameter int              FDEPTH = 32,
  parameter logic [DW-1:0]   REQ_OP = 8'h01,
  parameter logic [DW-1:0]   RSP_OP = 8'h02
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          noc_to_dev_ctl,
  input  logic [DW-1:0] noc_to_dev_data,
  output logic          noc_from_dev_ctl,
  output logic [DW-1:0] noc_from_dev_data,
  output logic          pushin,
  output logic          firstin,
  input  logic          stopin,
  output logic [LW-1:0] din,
  input  logic          pushout,
  input  logic          firstout,
  output logic          stopout,
  input  logic [LW-1:0] dout,
  output logic          proto_err
);
  localparam int BPL = LW / DW;
  localparam int AW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW  = $clog2(FDEPTH + 1);
  localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int LCW = $clog2(NLANES + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FDEPTH);
  localparam logic [CW-1:0]  NL_C    = CW'(NLANES);
  localparam logic [BW-1:0]  BLAST   = BW'(BPL - 1);
  localparam logic [LCW-1:0] LLAST   = LCW'(NLANES - 1);

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  typedef enum logic [1:0] {R_IDLE, R_PAY, R_SKIP} rstate_t;
  rstate_t rstate, rstate_d;

  logic [LW-1:0]  imem [FDEPTH];
  logic [LW-1:0]  lane_sr, lane_nx;
  logic [BW-1:0]  rb;
  logic [LCW-1:0] rl, rd_lane;
  logic [AW-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [CW-1:0]  in_used, in_avail, occ;
  logic           commit_pend, abort, hdr_ok, rej, byte_in, lane_wr, load;

  assign lane_nx = (lane_sr >> DW) | (LW'(noc_to_dev_data) << (LW - DW));
  assign load    = (in_avail != '0) && (!pushin || !stopin);

  always_comb begin
    rstate_d = rstate;
    abort    = 1'b0;
    hdr_ok   = 1'b0;
    rej      = 1'b0;
    byte_in  = 1'b0;
    lane_wr  = 1'b0;
    occ      = in_used;
    if (noc_to_dev_ctl) begin
      abort = (rstate == R_PAY);
      // an aborted packet's partial lanes do not count against free space
      occ   = abort ? in_avail : in_used;
      if (noc_to_dev_data == REQ_OP && (DEPTH_C - occ) >= NL_C) begin
        rstate_d = R_PAY;
        hdr_ok   = 1'b1;
      end else begin
        rstate_d = R_SKIP;
        rej      = (noc_to_dev_data == REQ_OP);
      end
    end else if (rstate == R_PAY) begin
      byte_in = 1'b1;
      lane_wr = (rb == BLAST);
      if (lane_wr && rl == LLAST) rstate_d = R_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate      <= R_IDLE;
      lane_sr     <= '0;
      rb          <= '0;
      rl          <= '0;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      rd_ptr      <= '0;
      rd_lane     <= '0;
      in_used     <= '0;
      in_avail    <= '0;
      commit_pend <= 1'b0;
      proto_err   <= 1'b0;
      pushin      <= 1'b0;
      firstin     <= 1'b0;
      din         <= '0;
    end else begin
      rstate      <= rstate_d;
      proto_err   <= abort | rej;
      commit_pend <= lane_wr && (rl == LLAST);
      if (hdr_ok) begin
        rb <= '0;
        rl <= '0;
      end else if (byte_in) begin
        lane_sr <= lane_nx;
        rb      <= lane_wr ? '0 : rb + 1'b1;
        if (lane_wr) rl <= rl + 1'b1;
      end
      if (abort)        wr_ptr <= commit_ptr;
      else if (lane_wr) wr_ptr <= inc(wr_ptr);
      if (commit_pend)  commit_ptr <= wr_ptr;
      in_avail <= in_avail + (commit_pend ? NL_C : '0) - CW'(load);
      in_used  <= (abort ? in_avail : in_used + CW'(lane_wr)) - CW'(load);
      if (load) begin
        din     <= imem[rd_ptr];
        firstin <= (rd_lane == '0);
        pushin  <= 1'b1;
        rd_ptr  <= inc(rd_ptr);
        rd_lane <= (rd_lane == LLAST) ? '0 : rd_lane + 1'b1;
      end else if (!stopin) begin
        pushin  <= 1'b0;
        firstin <= 1'b0;
      end
    end
  end

  logic [LW-1:0]     omem [FDEPTH];
  logic [FDEPTH-1:0] otag;
  logic [AW-1:0]     o_wr, o_rd;
  logic [CW-1:0]     o_cnt, o_cnt_nx;
  logic [LCW-1:0]    cap_cnt, cap_base;
  logic              push, pop;

  assign push     = pushout && (o_cnt != DEPTH_C);
  assign cap_base = firstout ? '0 : cap_cnt;
  assign o_cnt_nx = o_cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (lane_wr) imem[wr_ptr] <= lane_nx;
    if (push) begin
      omem[o_wr] <= dout;
      otag[o_wr] <= (cap_base == '0);
    end
  end

`ifdef PS_NOC_GW_CSUM_EN
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY, T_CSUM} tstate_t;
  logic [DW-1:0] csum;
`else
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tstate_t;
`endif
  tstate_t        tstate, tstate_d;
  logic [BW-1:0]  tb, tb_d;
  logic [LCW-1:0] tl, tl_d;
  logic           ctl_d;
  logic [DW-1:0]  data_d;
  logic [LW-1:0]  head;

  assign head = omem[o_rd];

  always_comb begin
    tstate_d = tstate;
    tb_d     = tb;
    tl_d     = tl;
    ctl_d    = 1'b0;
    data_d   = '0;
    pop      = 1'b0;
    case (tstate)
      T_IDLE: if (o_cnt != '0) begin
        if (otag[o_rd]) begin
          tstate_d = T_HDR;
          ctl_d    = 1'b1;
          data_d   = RSP_OP;
          tb_d     = '0;
          tl_d     = '0;
        end else begin
          pop = 1'b1;  // stray lane with no packet start: drop it
        end
      end
      T_HDR, T_PAY: begin
        tstate_d = T_PAY;
        if (o_cnt != '0) begin
          data_d = DW'(head >> (DW * int'(tb)));
          tb_d   = tb + 1'b1;
          if (tb == BLAST) begin
            pop  = 1'b1;
            tb_d = '0;
            tl_d = tl + 1'b1;
            if (tl == LLAST) begin
`ifdef PS_NOC_GW_CSUM_EN
              tstate_d = T_CSUM;
`else
              tstate_d = T_IDLE;
`endif
            end
          end
        end
      end
`ifdef PS_NOC_GW_CSUM_EN
      T_CSUM: begin
        data_d   = csum;
        tstate_d = T_IDLE;
      end
`endif
      default: tstate_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tstate            <= T_IDLE;
      tb                <= '0;
      tl                <= '0;
      noc_from_dev_ctl  <= 1'b0;
      noc_from_dev_data <= '0;
      o_wr              <= '0;
      o_rd              <= '0;
      o_cnt             <= '0;
      cap_cnt           <= '0;
      stopout           <= 1'b0;
`ifdef PS_NOC_GW_CSUM_EN
      csum              <= '0;
`endif
    end else begin
      tstate            <= tstate_d;
      tb                <= tb_d;
      tl                <= tl_d;
      noc_from_dev_ctl  <= ctl_d;
      noc_from_dev_data <= data_d;
      o_cnt             <= o_cnt_nx;
      stopout           <= (DEPTH_C - o_cnt_nx) <= CW'(2);
      if (push) begin
        o_wr    <= inc(o_wr);
        cap_cnt <= (cap_base == LLAST) ? '0 : cap_base + 1'b1;
      end
      if (pop) o_rd <= inc(o_rd);
`ifdef PS_NOC_GW_CSUM_EN
      // stall cycles carry data_d=0 and leave the checksum unchanged
      if (ctl_d) csum <= '0;
      else if (tstate == T_HDR || tstate == T_PAY) csum <= csum ^ data_d;
`endif
    end
  end
endmodule

// File: tb/tb_ps_noc_gw.sv
// tb/tb_ps_noc_gw.sv - randomized self-checking bench for ps_noc_gw
// Packet-level reference model for both directions; honours PS_NOC_GW_CSUM_EN.
module tb_ps_noc_gw;
  localparam int DW = 8, LW = 64, NL = 25, FD = 32, BPL = 8, NB = NL * BPL;
`ifdef PS_NOC_GW_CSUM_EN
  localparam int TXN = NB + 1;
`else
  localparam int TXN = NB;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          noc_to_dev_ctl, noc_from_dev_ctl;
  logic [DW-1:0] noc_to_dev_data, noc_from_dev_data;
  logic          pushin, firstin, stopin, pushout, firstout, stopout, proto_err;
  logic [LW-1:0] din, dout;

  ps_noc_gw dut (
    .clk(clk), .reset(reset),
    .noc_to_dev_ctl(noc_to_dev_ctl), .noc_to_dev_data(noc_to_dev_data),
    .noc_from_dev_ctl(noc_from_dev_ctl), .noc_from_dev_data(noc_from_dev_data),
    .pushin(pushin), .firstin(firstin), .stopin(stopin), .din(din),
    .pushout(pushout), .firstout(firstout), .stopout(stopout), .dout(dout),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_errs = 0;
  longint      cyc = 0, cap_cyc = 0;
  int          sin_mode = 0, exp_err = 0, got_err = 0, xfer_cnt = 0, rx_left = 0;
  bit          m_in_pay = 0, chk_lat = 0, so_seen = 0;
  logic [63:0] exp_lanes [$];
  bit          exp_first [$];
  logic [7:0]  pay_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  pl [NB];
  logic [63:0] pk [NL];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_byte(input logic c, input logic [7:0] d);
    bit e;
    if (c) begin
      e = m_in_pay;
      pay_q.delete();
      m_in_pay = 0;
      if (d == 8'h01) begin
        if (FD - exp_lanes.size() >= NL) m_in_pay = 1;
        else e = 1;
      end
      if (e) exp_err++;
    end else if (m_in_pay) begin
      pay_q.push_back(d);
      if (pay_q.size() == NB) begin
        for (int i = 0; i < NL; i++) begin
          logic [63:0] v = 0;
          for (int k = 0; k < BPL; k++) v = v + (64'(pay_q[i*BPL+k]) << (8 * k));
          exp_lanes.push_back(v);
          exp_first.push_back(i == 0);
        end
        pay_q.delete();
        m_in_pay = 0;
      end
    end
  endtask

  task automatic put_byte(input logic c, input logic [7:0] d);
    @(posedge clk); #1;
    noc_to_dev_ctl  = c;
    noc_to_dev_data = d;
    model_byte(c, d);
  endtask

  task automatic send_req(input int nbytes);
    put_byte(1'b1, 8'h01);
    for (int i = 0; i < nbytes; i++) put_byte(1'b0, pl[i]);
  endtask

  task automatic fill(input bit rnd);
    for (int i = 0; i < NB; i++) pl[i] = rnd ? 8'($urandom) : 8'(i);
  endtask

  task automatic send_pkt();
    logic [7:0] x = 0, b;
    int g;
    for (int i = 0; i < NL; i++)
      for (int k = 0; k < BPL; k++) begin
        b = 8'(pk[i] >> (8 * k));
        x = x ^ b;
        tx_q.push_back(b);
      end
`ifdef PS_NOC_GW_CSUM_EN
    tx_q.push_back(x);
`endif
    for (int i = 0; i < NL; i++) begin
      @(posedge clk); #1;
      g = 0;
      while (stopout && g < 1000) begin
        pushout = 0;
        @(posedge clk); #1;
        g++;
      end
      pushout  = 1;
      firstout = (i == 0);
      dout     = pk[i];
      if (i == 0) cap_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    pushout  = 0;
    firstout = 0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    put_byte(1'b0, 8'h00);
    while ((exp_lanes.size() != 0 || rx_left != 0 || tx_q.size() != 0) && g < 3000) begin
      @(posedge clk);
      g++;
    end
    chk({tag, "_drain_in_time"}, g < 3000, 1);
    repeat (4) @(posedge clk);
    chk({tag, "_proto_err_count"}, got_err, exp_err);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (sin_mode)
      0:       stopin = 0;
      1:       stopin = ~stopin;
      2:       stopin = 1'($urandom_range(0, 1));
      default: stopin = 1;
    endcase
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) if (reset) begin
    if (proto_err) got_err++;
    if (stopout) so_seen = 1;
    if (exp_lanes.size() == 0) chk("spurious_pushin", pushin, 0);
    else if (pushin) begin
      chk("din", din, exp_lanes[0]);
      chk("firstin", firstin, exp_first[0]);
      if (!stopin) begin
        void'(exp_lanes.pop_front());
        void'(exp_first.pop_front());
        xfer_cnt++;
      end
    end
    if (rx_left == 0) begin
      if (noc_from_dev_ctl) begin
        chk("tx_hdr_data", noc_from_dev_data, 8'h02);
        chk("tx_hdr_expected", tx_q.size() >= TXN, 1);
        if (chk_lat) begin
          chk("tx_hdr_latency", cyc - cap_cyc, 1);
          chk_lat = 0;
        end
        rx_left = TXN;
      end else chk("tx_idle_data", noc_from_dev_data, 0);
    end else begin
      chk("tx_pay_ctl", noc_from_dev_ctl, 0);
      chk("tx_pay_data", noc_from_dev_data, tx_q.size() > 0 ? 64'(tx_q.pop_front()) : 64'hDEAD);
      rx_left--;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, noc_from_dev_ctl, 0);
    chk({tag, "_data"}, noc_from_dev_data, 0);
    chk({tag, "_pushin"}, pushin, 0);
    chk({tag, "_firstin"}, firstin, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_stopout"}, stopout, 0);
    chk({tag, "_proto_err"}, proto_err, 0);
  endtask

  initial begin
    int e0, x0, cnt, kind;
    reset = 0; noc_to_dev_ctl = 0; noc_to_dev_data = 0; stopin = 0;
    pushout = 0; firstout = 0; dout = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("rst0");
    @(posedge clk); #1; reset = 1;

    fill(1);
    send_req(50);
    @(posedge clk); #1; reset = 0;
    exp_lanes.delete(); exp_first.delete(); pay_q.delete(); m_in_pay = 0;
    tx_q.delete(); rx_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("rst_mid");
    @(posedge clk); #1; reset = 1;

    fill(0);
    send_req(NB);
    put_byte(1'b0, 8'h00);
    @(negedge clk); chk("lat_n0_pushin", pushin, 0);
    @(negedge clk); chk("lat_n1_pushin", pushin, 0);
    @(negedge clk); chk("lat_n2_pushin", pushin, 1);
    chk("lane0_first", firstin, 1);
    chk("lane0_din", din, 64'h0706050403020100);
    cnt = 0;
    repeat (24) begin @(negedge clk); if (pushin) cnt++; end
    chk("no_gap_lanes", cnt, 24);
    drain("inc_req");

    sin_mode = 1;
    x0 = xfer_cnt;
    send_req(NB);
    drain("toggle");
    chk("toggle_xfers", xfer_cnt - x0, 25);
    sin_mode = 0;

    e0 = got_err;
    fill(1);
    send_req(37);
    send_req(NB);
    drain("abort");
    chk("abort_err_pulses", got_err - e0, 1);

    for (int i = 0; i < NL; i++) pk[i] = 64'hFFFF_0000_AAAA_5555;
    chk_lat = 1;
    send_pkt();
    drain("rsp_fixed");
    chk("rsp_latency_checked", chk_lat, 0);

    e0 = got_err;
    put_byte(1'b1, 8'h07);
    for (int i = 0; i < NB; i++) put_byte(1'b0, pl[i]);
    fill(1);
    send_req(NB);
    drain("bad_op");
    chk("bad_op_err_pulses", got_err - e0, 0);

    sin_mode = 3;
    e0 = got_err;
    send_req(NB);
    send_req(NB);
    repeat (3) @(posedge clk);
    chk("full_reject_err", got_err - e0, 1);
    sin_mode = 0;
    drain("full_reject");

    so_seen = 0;
    repeat (3) begin
      for (int i = 0; i < NL; i++) pk[i] = {$urandom, $urandom};
      send_pkt();
    end
    drain("rsp_burst");
    chk("stopout_seen", so_seen, 1);

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      sin_mode = $urandom_range(0, 2);
      fill(1);
      case (kind)
        0: send_req(NB);
        1: begin send_req($urandom_range(1, NB - 1)); send_req(NB); end
        2: begin
          put_byte(1'b1, 8'($urandom_range(2, 255)));
          for (int i = 0; i < $urandom_range(0, NB); i++) put_byte(1'b0, pl[i]);
          send_req(NB);
        end
        default: begin
          for (int i = 0; i < NL; i++) pk[i] = {$urandom, $urandom};
          send_pkt();
        end
      endcase
      drain("rand");
    end
    sin_mode = 0;
    chk("final_err_count", got_err, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/ps_noc_gw.md
# ps_noc_gw

Parametrised NoC gateway for the permutation subsystem. It receives a request packet from the NoC byte stream and assembles it into LW-bit lanes. It holds the whole state in a commit-protected lane FIFO and releases it to the permutation engine under a push/stop handshake. It captures the engine's result lanes and serialises them back onto the NoC as a response packet. It sits between the NoC device port and the permutation engine in the subsystem top, and generalises byte width, lane width, lanes per state and buffer depth.

## Interface
- DW, 8, NoC byte width
- LW, 64, lane width; must be a multiple of DW
- NLANES, 25, lanes per state (one packet)
- FDEPTH, 32, lanes per FIFO (inbound and outbound); must be ≥ NLANES
- REQ_OP, 8'h01, header opcode of a request
- RSP_OP, 8'h02, header opcode of a response
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- noc_to_dev_ctl  in  1  1 = header byte
- noc_to_dev_data  in  DW  inbound byte
- noc_from_dev_ctl  out  1  1 = header byte
- noc_from_dev_data  out  DW  outbound byte
- pushin  out  1  lane valid to engine
- firstin  out  1  lane 0 of a state
- stopin  in  1  engine backpressure
- din  out  LW  lane to engine
- pushout  in  1  result lane valid
- firstout  in  1  result lane 0
- stopout  out  1  backpressure to engine
- dout  in  LW  result lane
- proto_err  out  1  one-cycle pulse on packet abort

## Operation
- Receive FSM states: R_IDLE, R_PAY, R_SKIP.
  - ctl=1 with data==REQ_OP → R_PAY, clear the byte and lane counters.
  - ctl=1 with any other opcode → R_SKIP. Bytes are ignored until the next ctl=1.
  - In R_PAY each ctl=0 byte is shifted into the lane register, little-endian: the first byte is bits [DW-1:0].
  - After LW/DW bytes, the lane is written at wr_ptr.
  - After NLANES lanes, commit_ptr←wr_ptr and the FSM returns to R_IDLE.
- ctl=1 in R_PAY before the payload completes:
  - abort: wr_ptr←commit_ptr and the partial lane is discarded;
  - proto_err pulses;
  - the new header is decoded in the same cycle.
- A request arriving while the inbound FIFO has fewer than NLANES free entries is treated as a non-REQ header (R_SKIP), and proto_err pulses.
- Engine side: lanes between rd_ptr and commit_ptr are presented.
  - A transfer occurs on an edge where pushin=1 and stopin=0.
  - firstin=1 on the lane that is lane 0 of its packet.
- Result capture:
  - Each pushout=1 lane is written to the outbound FIFO.
  - firstout restarts the outbound lane count.
  - stopout=1 when the outbound FIFO has ≤ 2 free entries.
- Transmit FSM states: T_IDLE, T_HDR, T_PAY.
  - T_IDLE→T_HDR when the outbound FIFO holds a lane that is lane 0 of its packet.
  - T_HDR emits ctl=1, data=RSP_OP for one cycle.
  - T_PAY emits NLANES×LW/DW bytes, little-endian per lane, with ctl=0. It stalls (ctl=0, data=0) if the FIFO is momentarily empty.
  - Return to T_IDLE after the last byte.
- Idle NoC output: ctl=0, data=0.

## Timing
- Reset values: noc_from_dev_ctl=0, noc_from_dev_data=0, pushin=0, firstin=0, din=0, stopout=0, proto_err=0. All pointers, counters and FSMs are cleared.
- All outputs are registered.
- Reset mid-packet discards all buffered lanes in both directions.
- Inbound latency: the last payload byte sampled at edge N → commit at N+1 → pushin=1 with lane 0 at N+2.
- Holding rule: pushin, din and firstin stay stable while stopin=1. The next lane appears on the edge after a transfer, giving back-to-back lanes when stopin=0.
- Outbound latency: first result lane captured at edge M → header byte at M+1, first payload byte at M+2.
- Simultaneous inbound write and engine read of the same FIFO is supported every cycle. FIFO pointers wrap modulo FDEPTH.
- The NoC inbound side has no backpressure. Every byte is sampled every cycle.

## Configuration
- PS_NOC_GW_CSUM_EN
  - Defined: after the last payload byte, the transmit FSM enters T_CSUM and emits one ctl=0 byte equal to the XOR of all payload bytes of that response.
  - Undefined: T_CSUM does not exist, and the packet ends with the last payload byte.

## Test plan
- Reset held low for 3 cycles mid-packet, then released → all outputs 0; a following full request is processed normally.
- Request (header 8'h01, 200 bytes 0x00..0xC7) with stopin=0 → 25 lanes. Lane 0 = 64'h0706050403020100 with firstin=1, pushin rises 2 cycles after the last byte, no gaps.
- Same request with stopin toggling 1,0 every cycle → din is stable while stopin=1; exactly 25 transfers, in order.
- A second header 8'h01 after 37 payload bytes → proto_err pulses once, no lanes are pushed for the aborted packet, and the second packet arrives intact.
- Engine returns 25 lanes of 64'hFFFF_0000_AAAA_5555 → noc_from_dev header 8'h02 one cycle later, then 200 bytes repeating 55,55,AA,AA,00,00,FF,FF. With PS_NOC_GW_CSUM_EN, a trailing byte 8'h00 follows.
- Header 8'h07 followed by 200 bytes → no pushin, no proto_err; the next valid request works.
